// File: rtl/alu_mdu_seq.sv
// Sequential execute-stage ALU with valid/ready handshake, single-cycle logic/arith ops
// and iterative shift-add multiply / restoring divide.
module alu_mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

    logic             is_sub;
    logic [WIDTH:0]   sum_ext;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] step_acc, step_lo;
    logic             op_is_div;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Result    = res_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = c_q;
    assign V         = v_q;

    always_comb begin
        is_sub  = (ALUControl == 4'b0001);
        sum_ext = {1'b0, A} + {1'b0, (is_sub ? ~B : B)} + {{WIDTH{1'b0}}, is_sub};
        shamt   = B[SH_W-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            4'b0000, 4'b0001: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (sum_ext[WIDTH-1] ^ A[WIDTH-1]) & ~(A[WIDTH-1] ^ B[WIDTH-1] ^ is_sub);
            end
            4'b0010: alu_res = A & B;
            4'b0011: alu_res = A | B;
            4'b0100: alu_res = A ^ B;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            4'b0111: alu_res = A << shamt;
            4'b1000: alu_res = A >> shamt;
            4'b1001: alu_res = $signed(A) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // One iteration: multiply shifts {acc,lo} right after a conditional add, divide shifts
    // {acc,lo} left and subtracts when the partial remainder covers the divisor.
    always_comb begin
        op_is_div = (op_q[3:1] == 3'b110);
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        rem_sh    = {acc_q, lo_q[WIDTH-1]};
        div_diff  = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (op_is_div) begin
            if (!div_diff[WIDTH+1]) begin
                step_acc = div_diff[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = rem_sh[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        res_d   = res_q;
        c_d     = c_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = ALUControl;
                    if (ALUControl[3:2] == 2'b10 && ALUControl[1:0] != 2'b00 &&
                        ALUControl[1:0] != 2'b01 || ALUControl[3:1] == 3'b101 ||
                        ALUControl[3:1] == 3'b110) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        acc_d   = '0;
                        opnd_d  = (ALUControl[3:1] == 3'b110) ? B : A;
                        lo_d    = (ALUControl[3:1] == 3'b110) ? A : B;
                    end else begin
                        state_d = S_DONE;
                        res_d   = alu_res;
                        c_d     = alu_c;
                        v_d     = alu_v;
                    end
                end
            end
            S_BUSY: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = S_DONE;
                    res_d   = op_q[0] ? step_acc : step_lo;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        z_d = (state_q == S_DONE) ? z_q : (res_d == '0);
        n_d = (state_q == S_DONE) ? n_q : res_d[WIDTH-1];
        if (state_d != S_DONE || state_q == S_DONE) begin
            z_d = z_q;
            n_d = n_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
Parametrised sequential successor to the single-cycle execute-stage ALU. Adds registered results, a valid/ready handshake, a 4-bit operation code, shifts, unsigned compares, and iterative multiply/divide. Sits in the EX stage. The hazard unit stalls the pipeline while in_ready is low.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  unit can accept (high only in IDLE)
A  input  WIDTH  operand A
B  input  WIDTH  operand B
ALUControl  input  4  operation code
out_valid  output  1  Result/flags valid
out_ready  input  1  consumer takes result
Result  output  WIDTH  registered result
Z  output  1  zero flag
N  output  1  negative flag
C  output  1  carry flag
V  output  1  overflow flag

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous, active-high. All state updates on rising clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Result=0, Z=N=C=V=0, iteration counter and internal accumulators=0.
- Reset mid-operation: the operation is discarded, with no output pulse. IDLE is reached the cycle after rst is sampled.
- Accept: a handshake occurs when in_valid&&in_ready at a clk edge. A, B and ALUControl are captured; later input changes have no effect.
- Op codes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLT (signed)
  - 0110 SLTU
  - 0111 SLL
  - 1000 SRL
  - 1001 SRA
  - 1010 MUL (low WIDTH bits)
  - 1011 MULHU (high WIDTH bits, unsigned)
  - 1100 DIVU
  - 1101 REMU
  - 1110/1111: Result=0, flags computed on 0, no error.
- Arithmetic rules:
  - SUB is computed as A+~B+1.
  - Shift amount is B[$clog2(WIDTH)-1:0]; upper B bits are ignored.
  - SLT/SLTU give {0..,1} or 0.
- States:
  - IDLE: in_ready=1. Accepting a single-cycle op (0000-1001, 1110, 1111) computes the result combinationally, registers it, and goes to DONE. Accepting 1010-1101 goes to BUSY with counter=0.
  - BUSY: in_ready=0. Performs one shift-add (MUL/MULHU) or restoring-subtract (DIVU/REMU) step per cycle. After exactly WIDTH steps (counter==WIDTH-1 step taken), registers the result and goes to DONE.
  - DONE: out_valid=1. Goes to IDLE on out_ready. While out_ready=0, Result and flags hold stable.
- Latency, counted from the accept edge:
  - Single-cycle ops: out_valid is high after 1 edge.
  - MUL/DIV ops: out_valid is high after WIDTH+1 edges.
  - Minimum issue interval: 2 cycles (single-cycle ops) or WIDTH+2 cycles (MUL/DIV ops).
- Divide by zero:
  - DIVU gives all ones.
  - REMU gives A.
  - No exception is raised; full WIDTH cycles are still consumed.
- Flags are registered together with Result:
  - Z = (Result==0).
  - N = Result[WIDTH-1].
  - C: ADD gives the carry out of bit WIDTH-1. SUB gives the carry out of A+~B+1 (1 means no borrow). 0 for all other ops.
  - V: for ADD/SUB only, V = (Sum[MSB]^A[MSB]) & ~(A[MSB]^B[MSB]^op_is_sub). 0 otherwise.
- Simultaneous events:
  - rst has priority over everything.
  - in_valid during BUSY/DONE is ignored (in_ready=0).
  - The out_ready handshake in DONE and a new accept cannot coincide; the new accept happens in IDLE on the next cycle.

Test Plan:
- Reset: assert rst 2 cycles mid-BUSY of a MUL → next cycle in_ready=1, out_valid=0, Result=0, flags=0; no out_valid pulse.
- ADD 0x7FFFFFFF+0x00000001 → 1 edge later out_valid=1, Result=0x80000000, N=1, V=1, C=0, Z=0. SUB 5-5 → Result=0, Z=1, C=1, V=0.
- Shifts: SRA A=0x80000000, B=0x00000024 (shamt=4) → Result=0xF8000000. SLL A=1, B=31 → Result=0x80000000. SLTU 1 vs 0xFFFFFFFF → Result=1; SLT same operands → Result=0.
- MUL 0xFFFFFFFF*0xFFFFFFFF: low → 0x00000001; MULHU → 0xFFFFFFFE. out_valid rises exactly 33 edges after accept; in_ready=0 throughout.
- DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 123/0 → 0xFFFFFFFF; REMU 123/0 → 123. Each takes 33 edges.
- Backpressure: hold out_ready=0 for 5 cycles after an AND 0xF0F0F0F0&0xFF00FF00 → Result=0xF000F000 stable and in_ready=0 throughout. Raise out_ready → IDLE the next cycle. A new in_valid toggled during the wait is not accepted.
